cfg_tieoff_loader: RTL

Parametrised, field-loadable replacement for the static configuration tie-offs. It drives the card- and AFU-specific read-only configuration fields for `NUM_AFU` AFUs. After reset the outputs hold parameter defaults. A checksummed word stream from the board loader (flash/VPD shadow) may overwrite them once, and then the block locks. It sits between the board loader and the cfg_func0/cfg_func1 instances; `cfg_ready` gates configuration-space responses.

---
 rtl/cfg_cardinfo_pkg.sv | 42 ++++
 rtl/cfg_tieoff_afu_regs.sv | 59 +++++
 rtl/cfg_tieoff_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cfg_cardinfo_pkg.sv
// Shared definitions for the card/AFU configuration tie-off loader:
// FSM states, load word map and AFU control-word field positions.
package cfg_cardinfo_pkg;

  localparam int MAX_AFU = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT,
    ST_LOCKED,
    ST_ERROR
  } cfg_state_t;

  localparam logic [7:0] ADDR_IDS       = 8'd0;
  localparam logic [7:0] ADDR_SERIAL_LO = 8'd1;
  localparam logic [7:0] ADDR_SERIAL_HI = 8'd2;
  localparam logic [7:0] ADDR_AFU_BASE  = 8'd4;

  localparam int ACTAG_LSB = 0;
  localparam int ACTAG_W   = 12;
  localparam int PASID_LSB = 12;
  localparam int PASID_W   = 5;
  localparam int RDUR_LSB  = 17;
  localparam int RDUR_W    = 8;

  function automatic logic [7:0] afuBarAddr(input int afu);
    return ADDR_AFU_BASE + 8'(2 * afu);
  endfunction

  function automatic logic [7:0] afuCtlAddr(input int afu);
    return afuBarAddr(afu) + 8'd1;
  endfunction

  // Address 3 is a hole in the map and counts as out-of-range.
  function automatic logic addrInRange(input logic [7:0] addr, input int numAfu);
    return (addr <= ADDR_SERIAL_HI) ||
           ((addr >= ADDR_AFU_BASE) && ({24'b0, addr} <= 32'(3 + 2 * numAfu)));
  endfunction

endpackage

// File: rtl/cfg_tieoff_afu_regs.sv
// One AFU's shadow and active configuration fields; the shadow is loaded
// beat by beat and copied to the active set on a single commit pulse.
module cfg_tieoff_afu_regs
  import cfg_cardinfo_pkg::*;
#(
  parameter logic [31:0] DEF_BAR0_SIZE_HI = 32'hFFFF_FFFF,
  parameter logic [11:0] DEF_ACTAG_LEN    = 12'h020,
  parameter logic [4:0]  DEF_PASID_LEN    = 5'b01001,
  parameter logic [7:0]  DEF_RESET_DUR    = 8'h10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_wrBar,
  input  logic        i_wrCtl,
  input  logic        i_commit,
  input  logic [31:0] i_wrData,
  output logic [31:0] o_bar0Hi,
  output logic [11:0] o_actagLen,
  output logic [4:0]  o_pasidLen,
  output logic [7:0]  o_resetDur
);

  logic [31:0] r_shBar0Hi, r_actBar0Hi;
  logic [11:0] r_shActag,  r_actActag;
  logic [4:0]  r_shPasid,  r_actPasid;
  logic [7:0]  r_shRdur,   r_actRdur;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shBar0Hi  <= DEF_BAR0_SIZE_HI;
      r_shActag   <= DEF_ACTAG_LEN;
      r_shPasid   <= DEF_PASID_LEN;
      r_shRdur    <= DEF_RESET_DUR;
      r_actBar0Hi <= DEF_BAR0_SIZE_HI;
      r_actActag  <= DEF_ACTAG_LEN;
      r_actPasid  <= DEF_PASID_LEN;
      r_actRdur   <= DEF_RESET_DUR;
    end else begin
      if (i_wrBar) r_shBar0Hi <= i_wrData;
      if (i_wrCtl) begin
        r_shActag <= i_wrData[ACTAG_LSB +: ACTAG_W];
        r_shPasid <= i_wrData[PASID_LSB +: PASID_W];
        r_shRdur  <= i_wrData[RDUR_LSB +: RDUR_W];
      end
      if (i_commit) begin
        r_actBar0Hi <= r_shBar0Hi;
        r_actActag  <= r_shActag;
        r_actPasid  <= r_shPasid;
        r_actRdur   <= r_shRdur;
      end
    end
  end

  assign o_bar0Hi   = r_actBar0Hi;
  assign o_actagLen = r_actActag;
  assign o_pasidLen = r_actPasid;
  assign o_resetDur = r_actRdur;

endmodule

// File: rtl/cfg_tieoff_loader.sv
// Field-loadable configuration tie-offs: parameter defaults after reset,
// optionally overwritten once by a checksummed word stream, then locked.
module cfg_tieoff_loader
  import cfg_cardinfo_pkg::*;
#(
  parameter int          NUM_AFU              = 1,
  parameter int          TIMEOUT_CYCLES       = 4096,
  parameter logic [15:0] DEF_SUBSYS_ID        = 16'h060D,
  parameter logic [15:0] DEF_SUBSYS_VENDOR_ID = 16'h1014,
  parameter logic [63:0] DEF_SERIAL           = 64'hDEAD_DEAD_DEAD_DEAD,
  parameter logic [31:0] DEF_BAR0_SIZE_HI     = 32'hFFFF_FFFF,
  parameter logic [11:0] DEF_ACTAG_LEN        = 12'h020,
  parameter logic [4:0]  DEF_PASID_LEN        = 5'b01001,
  parameter logic [7:0]  DEF_RESET_DUR        = 8'h10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [7:0]             ld_addr,
  input  logic [31:0]            ld_data,
  input  logic                   ld_last,
  output logic [15:0]            ro_subsystem_id,
  output logic [15:0]            ro_subsystem_vendor_id,
  output logic [63:0]            ro_serial_number,
  output logic [NUM_AFU*64-1:0]  ro_bar0_size,
  output logic [NUM_AFU*12-1:0]  ro_actag_len,
  output logic [NUM_AFU*5-1:0]   ro_pasid_len,
  output logic [NUM_AFU*8-1:0]   ro_reset_duration,
  output logic                   cfg_ready,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  cfg_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_sum, r_expSum;
  logic             r_bad, r_loaded, r_commit;
  logic             r_ldReady, r_cfgReady, r_loadDone, r_loadErr;

  logic [15:0] r_shSubsys, r_shVendor, r_actSubsys, r_actVendor;
  logic [63:0] r_shSerial, r_actSerial;

  logic               w_accept, w_dataBeat;
  logic [NUM_AFU-1:0] w_wrBar, w_wrCtl;

  assign w_accept   = ld_valid & r_ldReady;
  assign w_dataBeat = w_accept & ~ld_last;

  // ld_ready is driven from the next state so it drops on the very edge
  // that accepts the last beat; the status flags follow the current state,
  // which puts them one edge behind the COMMIT/ERROR transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_sum      <= '0;
      r_expSum   <= '0;
      r_bad      <= 1'b0;
      r_loaded   <= 1'b0;
      r_commit   <= 1'b0;
      r_ldReady  <= 1'b0;
      r_cfgReady <= 1'b0;
      r_loadDone <= 1'b0;
      r_loadErr  <= 1'b0;
    end else begin
      r_commit   <= 1'b0;
      r_cfgReady <= (r_state == ST_LOCKED) || (r_state == ST_ERROR);
      r_loadDone <= (r_state == ST_LOCKED) && r_loaded;
      r_loadErr  <= (r_state == ST_ERROR);
      if (w_dataBeat) begin
        r_sum <= r_sum + ld_data;
        if (!addrInRange(ld_addr, NUM_AFU)) r_bad <= 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          r_ldReady <= 1'b1;
          if (w_accept) begin
            r_count <= '0;
            if (ld_last) begin
              r_expSum  <= ld_data;
              r_ldReady <= 1'b0;
              r_state   <= ST_CHECK;
            end else begin
              r_state <= ST_LOAD;
            end
          end else if (r_count == CNT_MAX) begin
            r_ldReady <= 1'b0;
            r_state   <= (r_state == ST_IDLE) ? ST_LOCKED : ST_ERROR;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          r_state <= ((r_sum == r_expSum) && !r_bad) ? ST_COMMIT : ST_ERROR;
        end
        ST_COMMIT: begin
          r_commit <= 1'b1;
          r_loaded <= 1'b1;
          r_state  <= ST_LOCKED;
        end
        default: begin
          r_ldReady <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shSubsys  <= DEF_SUBSYS_ID;
      r_shVendor  <= DEF_SUBSYS_VENDOR_ID;
      r_shSerial  <= DEF_SERIAL;
      r_actSubsys <= DEF_SUBSYS_ID;
      r_actVendor <= DEF_SUBSYS_VENDOR_ID;
      r_actSerial <= DEF_SERIAL;
    end else begin
      if (w_dataBeat) begin
        case (ld_addr)
          ADDR_IDS:       {r_shVendor, r_shSubsys} <= ld_data;
          ADDR_SERIAL_LO: r_shSerial[31:0]         <= ld_data;
          ADDR_SERIAL_HI: r_shSerial[63:32]        <= ld_data;
          default: ;
        endcase
      end
      if (r_commit) begin
        r_actSubsys <= r_shSubsys;
        r_actVendor <= r_shVendor;
        r_actSerial <= r_shSerial;
      end
    end
  end

  for (genvar a = 0; a < NUM_AFU; a++) begin : g_afu
    assign w_wrBar[a] = w_dataBeat && (ld_addr == afuBarAddr(a));
    assign w_wrCtl[a] = w_dataBeat && (ld_addr == afuCtlAddr(a));
    assign ro_bar0_size[64*a +: 32] = 32'h0;

    cfg_tieoff_afu_regs #(
      .DEF_BAR0_SIZE_HI (DEF_BAR0_SIZE_HI),
      .DEF_ACTAG_LEN    (DEF_ACTAG_LEN),
      .DEF_PASID_LEN    (DEF_PASID_LEN),
      .DEF_RESET_DUR    (DEF_RESET_DUR)
    ) u_afuRegs (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_wrBar    (w_wrBar[a]),
      .i_wrCtl    (w_wrCtl[a]),
      .i_commit   (r_commit),
      .i_wrData   (ld_data),
      .o_bar0Hi   (ro_bar0_size[64*a+32 +: 32]),
      .o_actagLen (ro_actag_len[12*a +: 12]),
      .o_pasidLen (ro_pasid_len[5*a +: 5]),
      .o_resetDur (ro_reset_duration[8*a +: 8])
    );
  end

  assign ld_ready               = r_ldReady;
  assign cfg_ready              = r_cfgReady;
  assign load_done              = r_loadDone;
  assign load_err               = r_loadErr;
  assign ro_subsystem_id        = r_actSubsys;
  assign ro_subsystem_vendor_id = r_actVendor;
  assign ro_serial_number       = r_actSerial;

endmodule
